// File: rtl/enemy_chaser.sv
// Hostile NPC: chases the player, strikes on contact, takes directional hits, dies and respawns.
// Latency: every output is registered; a player input change is visible one cycle later.
// Backpressure: none; the player's position and animation code are sampled on every cycle.
module enemy_chaser #(
  parameter int SPAWN_H      = 300,
  parameter int SPAWN_V      = 110,
  parameter int MAX_HP       = 3,
  parameter int MOVE_DIV     = 4,
  parameter int CONTACT      = 12,
  parameter int ATTACK_RANGE = 24,
  parameter int INVULN       = 100,
  parameter int RESPAWN      = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] stage,
  input  logic [9:0] player_pos_h,
  input  logic [9:0] player_pos_v,
  input  logic [3:0] player_state,
  output logic [9:0] pos_h,
  output logic [9:0] pos_v,
  output logic [1:0] state,
  output logic [3:0] hp,
  output logic       is_attacked,
  output logic [7:0] kills
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHASE = 2'd1,
    ST_HURT  = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // Timer is shared by HURT and DEAD; 16 bits covers any sensible duration.
  localparam int TW  = 16;
  localparam int MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [9:0]     SPAWN_H_L  = 10'(SPAWN_H);
  localparam logic [9:0]     SPAWN_V_L  = 10'(SPAWN_V);
  localparam logic [3:0]     HP_INIT    = 4'(MAX_HP);
  localparam logic [10:0]    CONTACT_L  = 11'(CONTACT);
  localparam logic [10:0]    RANGE_L    = 11'(ATTACK_RANGE);
  localparam logic [TW-1:0]  INVULN_LD  = TW'(INVULN - 1);
  localparam logic [TW-1:0]  RESPAWN_LD = TW'(RESPAWN - 1);
  localparam logic [MCW-1:0] MC_LAST    = MCW'(MOVE_DIV - 1);

  // Animation codes of the four directional attacks.
  localparam logic [3:0] ATK_FRONT = 4'hA;
  localparam logic [3:0] ATK_BACK  = 4'hB;
  localparam logic [3:0] ATK_LEFT  = 4'hC;
  localparam logic [3:0] ATK_RIGHT = 4'hD;

  // Registered state
  state_t         state_q, state_d;
  logic [9:0]     pos_h_q, pos_h_d;
  logic [9:0]     pos_v_q, pos_v_d;
  logic [3:0]     hp_q, hp_d;
  logic           is_att_q, is_att_d;
  logic [7:0]     kills_q, kills_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;

  // Geometry: 11-bit two's complement deltas (bit 10 is the sign) and magnitudes
  logic [10:0] dx, dy;
  logic [10:0] adx, ady;
  logic        contact;
  logic        non_play;
  logic        atk_hit;
  logic        hit;
  logic [9:0]  step_h, step_v;

  // Signed deltas between enemy and player, their magnitudes and the contact box test
  always_comb begin
    dx      = {1'b0, pos_h_q} - {1'b0, player_pos_h};
    dy      = {1'b0, pos_v_q} - {1'b0, player_pos_v};
    adx     = dx[10] ? (~dx + 11'd1) : dx;
    ady     = dy[10] ? (~dy + 11'd1) : dy;
    contact = (adx <= CONTACT_L) && (ady <= CONTACT_L);
  end

  // Stages 0, E and F are menus/transitions where the enemy is parked at spawn
  always_comb begin
    non_play = (stage == 4'h0) || (stage == 4'hE) || (stage == 4'hF);
  end

  // Directional attack decode: enemy must sit in front of the player's facing, within reach,
  // and laterally inside the contact half-width
  always_comb begin
    atk_hit = 1'b0;
    case (player_state)
      // Facing down (toward -v): enemy below the player
      ATK_FRONT: atk_hit = dy[10] && (ady <= RANGE_L) && (adx <= CONTACT_L);
      // Facing up (toward +v): enemy above the player
      ATK_BACK:  atk_hit = !dy[10] && (dy != 11'd0) && (ady <= RANGE_L) && (adx <= CONTACT_L);
      // Facing left (toward +h): enemy to the player's left
      ATK_LEFT:  atk_hit = !dx[10] && (dx != 11'd0) && (adx <= RANGE_L) && (ady <= CONTACT_L);
      // Facing right (toward -h): enemy to the player's right
      ATK_RIGHT: atk_hit = dx[10] && (adx <= RANGE_L) && (ady <= CONTACT_L);
      default:   atk_hit = 1'b0;
    endcase
    hit = (state_q == ST_CHASE) && atk_hit;
  end

  // One-pixel step toward the player on the dominant axis; ties resolve horizontally.
  // The step always heads toward an in-range coordinate, so it cannot wrap.
  always_comb begin
    step_h = pos_h_q;
    step_v = pos_v_q;
    if (adx >= ady) begin
      if (dx[10]) begin
        step_h = pos_h_q + 10'd1;
      end else if (dx != 11'd0) begin
        step_h = pos_h_q - 10'd1;
      end
    end else begin
      if (dy[10]) begin
        step_v = pos_v_q + 10'd1;
      end else begin
        step_v = pos_v_q - 10'd1;
      end
    end
  end

  // Next-state logic: non-play override first, then the per-state behaviour
  always_comb begin
    state_d = state_q;
    pos_h_d = pos_h_q;
    pos_v_d = pos_v_q;
    hp_d    = hp_q;
    kills_d = kills_q;
    timer_d = timer_q;
    mcnt_d  = '0;

    if (non_play) begin
      state_d = ST_IDLE;
      pos_h_d = SPAWN_H_L;
      pos_v_d = SPAWN_V_L;
      hp_d    = HP_INIT;
      timer_d = '0;
      // Stage F keeps the tally visible (end screen); 0 and E start a fresh game
      kills_d = (stage == 4'hF) ? kills_q : 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CHASE;
        end

        ST_CHASE: begin
          if (hit) begin
            // A hit wins over movement; the counter restarts on re-entry to CHASE
            hp_d = hp_q - 4'd1;
            if (hp_q == 4'd1) begin
              state_d = ST_DEAD;
              timer_d = RESPAWN_LD;
              kills_d = (kills_q == 8'hFF) ? kills_q : kills_q + 8'd1;
            end else begin
              state_d = ST_HURT;
              timer_d = INVULN_LD;
            end
          end else begin
            if ((mcnt_q == '0) && !contact) begin
              pos_h_d = step_h;
              pos_v_d = step_v;
            end
            mcnt_d = (mcnt_q == MC_LAST) ? '0 : mcnt_q + MCW'(1);
          end
        end

        ST_HURT: begin
          if (timer_q == '0) begin
            state_d = ST_CHASE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end

        ST_DEAD: begin
          if (timer_q == '0) begin
            state_d = ST_CHASE;
            pos_h_d = SPAWN_H_L;
            pos_v_d = SPAWN_V_L;
            hp_d    = HP_INIT;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Strike only while chasing next cycle; contact is judged on the current positions
    is_att_d = (state_d == ST_CHASE) && contact;
  end

  // State registers with synchronous reset to the parked spawn condition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_h_q  <= SPAWN_H_L;
      pos_v_q  <= SPAWN_V_L;
      hp_q     <= HP_INIT;
      is_att_q <= 1'b0;
      kills_q  <= 8'd0;
      timer_q  <= '0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_h_q  <= pos_h_d;
      pos_v_q  <= pos_v_d;
      hp_q     <= hp_d;
      is_att_q <= is_att_d;
      kills_q  <= kills_d;
      timer_q  <= timer_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign pos_h       = pos_h_q;
  assign pos_v       = pos_v_q;
  assign state       = state_q;
  assign hp          = hp_q;
  assign is_attacked = is_att_q;
  assign kills       = kills_q;

endmodule

// File: tb/tb_enemy_chaser.sv
// Bench for enemy_chaser: directed combat scenarios plus randomized play against a reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: none; inputs are driven freely between edges.
module tb_enemy_chaser;

  localparam int SPAWN_H      = 300;
  localparam int SPAWN_V      = 110;
  localparam int MAX_HP       = 3;
  localparam int MOVE_DIV     = 4;
  localparam int CONTACT      = 12;
  localparam int ATTACK_RANGE = 24;
  localparam int INVULN       = 100;
  localparam int RESPAWN      = 250;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] stage;
  logic [9:0] player_pos_h, player_pos_v;
  logic [3:0] player_state;
  logic [9:0] pos_h, pos_v;
  logic [1:0] state;
  logic [3:0] hp;
  logic       is_attacked;
  logic [7:0] kills;

  always #5 clk = ~clk;

  enemy_chaser #(
    .SPAWN_H(SPAWN_H), .SPAWN_V(SPAWN_V), .MAX_HP(MAX_HP), .MOVE_DIV(MOVE_DIV),
    .CONTACT(CONTACT), .ATTACK_RANGE(ATTACK_RANGE), .INVULN(INVULN), .RESPAWN(RESPAWN)
  ) dut (
    .clk(clk), .rst(rst), .stage(stage),
    .player_pos_h(player_pos_h), .player_pos_v(player_pos_v), .player_state(player_state),
    .pos_h(pos_h), .pos_v(pos_v), .state(state), .hp(hp),
    .is_attacked(is_attacked), .kills(kills)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integers, behaviour written from the game rules
  int m_state, m_ph, m_pv, m_hp, m_att, m_kills, m_timer, m_mcnt;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  task automatic model_reset();
    m_state = 0; m_ph = SPAWN_H; m_pv = SPAWN_V; m_hp = MAX_HP;
    m_att = 0; m_kills = 0; m_timer = 0; m_mcnt = 0;
  endtask

  task automatic model_step();
    int  dx, dy, along, side, nxt;
    bit  facing, contact, hit, play;
    dx = m_ph - int'(player_pos_h);
    dy = m_pv - int'(player_pos_v);
    contact = (iabs(dx) <= CONTACT) && (iabs(dy) <= CONTACT);
    // Distance along the attack's facing axis and lateral offset from it
    facing = 1'b1; along = 0; side = 0;
    case (int'(player_state))
      10: begin along = -dy; side = dx; end
      11: begin along =  dy; side = dx; end
      12: begin along =  dx; side = dy; end
      13: begin along = -dx; side = dy; end
      default: facing = 1'b0;
    endcase
    hit  = (m_state == 1) && facing && (along > 0) && (along <= ATTACK_RANGE) && (iabs(side) <= CONTACT);
    play = !(stage == 4'h0 || stage == 4'hE || stage == 4'hF);
    nxt  = m_state;
    if (!play) begin
      nxt = 0; m_ph = SPAWN_H; m_pv = SPAWN_V; m_hp = MAX_HP; m_timer = 0; m_mcnt = 0;
      if (stage != 4'hF) m_kills = 0;
    end else if (m_state == 0) begin
      nxt = 1; m_mcnt = 0;
    end else if (m_state == 1) begin
      if (hit) begin
        m_hp = m_hp - 1; m_mcnt = 0;
        if (m_hp == 0) begin
          nxt = 3; m_timer = RESPAWN - 1;
          if (m_kills < 255) m_kills = m_kills + 1;
        end else begin
          nxt = 2; m_timer = INVULN - 1;
        end
      end else begin
        if (m_mcnt == 0 && !contact) begin
          if (iabs(dx) >= iabs(dy)) m_ph = m_ph - sgn(dx);
          else                      m_pv = m_pv - sgn(dy);
        end
        m_mcnt = (m_mcnt + 1) % MOVE_DIV;
      end
    end else begin
      m_mcnt = 0;
      if (m_timer == 0) begin
        nxt = 1;
        if (m_state == 3) begin m_ph = SPAWN_H; m_pv = SPAWN_V; m_hp = MAX_HP; end
      end else begin
        m_timer = m_timer - 1;
      end
    end
    m_att   = ((nxt == 1) && contact) ? 1 : 0;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check_eq("state", 32'(state), m_state);
    check_eq("pos_h", 32'(pos_h), m_ph);
    check_eq("pos_v", 32'(pos_v), m_pv);
    check_eq("hp", 32'(hp), m_hp);
    check_eq("is_attacked", 32'(is_attacked), m_att);
    check_eq("kills", 32'(kills), m_kills);
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  int seg_len, r, v;

  initial begin
    rst = 1'b1; stage = 4'h0;
    player_pos_h = 10'd150; player_pos_v = 10'd110; player_state = 4'h7;
    tick(); tick();
    check_eq("reset_state", 32'(state), 0);
    check_eq("reset_pos_h", 32'(pos_h), SPAWN_H);
    check_eq("reset_hp", 32'(hp), MAX_HP);
    rst = 1'b0;

    // Chase toward (150,110) until contact at 162
    stage = 4'h1;
    repeat (560) tick();
    check_eq("chase_stop_h", 32'(pos_h), 162);
    check_eq("chase_contact", 32'(is_attacked), 1);

    // Left attack hit, then HURT for exactly INVULN cycles
    player_state = 4'hC; tick(); player_state = 4'h7;
    check_eq("hit1_hp", 32'(hp), 2);
    check_eq("hit1_state", 32'(state), 2);
    check_eq("hit1_att", 32'(is_attacked), 0);
    repeat (INVULN - 1) tick();
    check_eq("hurt_still", 32'(state), 2);
    tick();
    check_eq("hurt_end", 32'(state), 1);

    // Wrong facing does nothing
    player_state = 4'hD;
    repeat (5) tick();
    check_eq("wrong_face_hp", 32'(hp), 2);
    check_eq("wrong_face_state", 32'(state), 1);
    player_state = 4'h7; tick();

    // Second and third hits: death, then respawn after RESPAWN cycles
    player_state = 4'hC; tick(); player_state = 4'h7;
    repeat (INVULN) tick();
    player_state = 4'hC; tick(); player_state = 4'h7;
    check_eq("death_state", 32'(state), 3);
    check_eq("death_kills", 32'(kills), 1);
    repeat (RESPAWN - 1) tick();
    check_eq("dead_still", 32'(state), 3);
    tick();
    check_eq("respawn_state", 32'(state), 1);
    check_eq("respawn_h", 32'(pos_h), SPAWN_H);
    check_eq("respawn_v", 32'(pos_v), SPAWN_V);
    check_eq("respawn_hp", 32'(hp), MAX_HP);

    // Stage abort during HURT
    player_pos_h = 10'd288; repeat (3) tick();
    player_state = 4'hC; tick(); player_state = 4'h7;
    check_eq("abort_pre_state", 32'(state), 2);
    repeat (10) tick();
    stage = 4'hE; tick();
    check_eq("abort_state", 32'(state), 0);
    check_eq("abort_h", 32'(pos_h), SPAWN_H);
    check_eq("abort_hp", 32'(hp), MAX_HP);
    check_eq("abort_kills", 32'(kills), 0);
    check_eq("abort_att", 32'(is_attacked), 0);

    // Diagonal tie goes horizontal
    stage = 4'h1; player_pos_h = 10'd280; player_pos_v = 10'd90;
    tick(); tick();
    check_eq("tie_h", 32'(pos_h), 299);
    check_eq("tie_v", 32'(pos_v), 110);

    // Randomized play around the enemy
    repeat (150) begin
      seg_len = int'($urandom_range(1, 40));
      r = int'($urandom_range(0, 99));
      if (r < 85) stage = 4'($urandom_range(1, 13));
      else if (r < 90) stage = 4'h0;
      else if (r < 95) stage = 4'hE;
      else stage = 4'hF;
      v = m_ph + int'($urandom_range(0, 80)) - 40;
      player_pos_h = 10'((v < 0) ? 0 : ((v > 1023) ? 1023 : v));
      v = m_pv + int'($urandom_range(0, 80)) - 40;
      player_pos_v = 10'((v < 0) ? 0 : ((v > 1023) ? 1023 : v));
      if ($urandom_range(0, 1) == 1) player_state = 4'($urandom_range(10, 13));
      else                           player_state = 4'($urandom_range(0, 15));
      repeat (seg_len) tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
